// File: rtl/ysyx_23060072_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices and counter helpers.
package ysyx_23060072_pipe_ctrl_pkg;

    typedef enum int unsigned {
        StIf,
        StId,
        StEx,
        StLsu,
        StWb,
        StNum
    } stage_e;

    localparam int unsigned CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // Saturating increment; sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(cnt_t v, logic en);
        return (en && (v != '1)) ? v + cnt_t'(1) : v;
    endfunction

endpackage

// File: rtl/ysyx_23060072_prio_arb.sv
// Fixed-priority arbiter: the lowest-index asserted request wins.
module ysyx_23060072_prio_arb #(
    parameter int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // Walk from the top so the lowest asserted index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline control: stall propagation, bubble insertion, redirect arbitration/issue,
// fetch squash window, hold timeout and stall/flush statistics.
module ysyx_23060072_pipe_ctrl
    import ysyx_23060072_pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE    = int'(StNum),
    parameter int unsigned NRED      = 2,
    parameter int unsigned RED_STAGE = int'(StEx),
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned TMO       = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSTAGE-1:0]    hold_req_i,
    input  logic [NRED-1:0]      red_req_i,
    input  logic [NRED*XLEN-1:0] red_pc_i,
    output logic [NSTAGE-1:0]    hold_o,
    output logic [NSTAGE-1:0]    bubble_o,
    output logic [NSTAGE-1:0]    flush_o,
    output logic                 red_valid_o,
    output logic [XLEN-1:0]      red_pc_o,
    output logic                 tmo_o,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o
);

    localparam int unsigned IW = (NRED > 1) ? $clog2(NRED) : 1;
    localparam int unsigned TW = $clog2(TMO + 1);

    logic            hold_acc;
    logic            red_any;
    logic [IW-1:0]   red_win;
    logic [XLEN-1:0] win_pc;
    logic            issue;
    logic            pend_load;

    logic            pend_q;
    logic [IW-1:0]   pend_src_q;
    logic [XLEN-1:0] pend_pc_q;
    logic [3:0]      fcnt_q;
    logic [TW-1:0]   hold_cnt_q;
    logic            tmo_q;
    cnt_t            stall_cnt_q;
    cnt_t            flush_cnt_q;

    ysyx_23060072_prio_arb #(
        .N(NRED)
    ) u_arb (
        .req  (red_req_i),
        .grant(red_win),
        .valid(red_any)
    );

    // A stall in any younger-or-equal stage index backs up everything upstream of it.
    always_comb begin
        hold_o   = '0;
        hold_acc = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            hold_acc  = hold_acc | hold_req_i[k];
            hold_o[k] = hold_acc & ~rst;
        end
    end

    always_comb begin
        bubble_o = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            bubble_o[k] = hold_o[k-1] & ~hold_o[k];
        end
    end

    always_comb begin
        win_pc = '0;
        for (int i = 0; i < NRED; i++) begin
            if (red_win == IW'(i)) begin
                win_pc = red_pc_i[i*XLEN +: XLEN];
            end
        end
    end

    assign issue       = pend_q & ~hold_o[0] & ~rst;
    assign red_valid_o = issue;
    assign red_pc_o    = issue ? pend_pc_q : '0;

    // A departing redirect frees the slot, so a same-cycle request always lands.
    assign pend_load = red_any & (~pend_q | issue | (red_win <= pend_src_q));

    // Flush has priority over hold in the stage registers that consume both.
    always_comb begin
        flush_o = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            flush_o[k] = ~rst & (((k < int'(RED_STAGE)) & red_any) |
                                 ((k == 0) & (issue | (fcnt_q != 4'd0))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_src_q  <= '0;
            pend_pc_q   <= '0;
            fcnt_q      <= 4'd0;
            hold_cnt_q  <= '0;
            tmo_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pend_load) begin
                pend_q     <= 1'b1;
                pend_src_q <= red_win;
                pend_pc_q  <= win_pc;
            end else if (issue) begin
                pend_q <= 1'b0;
            end

            if (issue) begin
                fcnt_q <= 4'(FLUSH_CYC);
            end else if (fcnt_q != 4'd0) begin
                fcnt_q <= fcnt_q - 4'd1;
            end

            if (hold_o[0]) begin
                if (hold_cnt_q != TW'(TMO)) begin
                    hold_cnt_q <= hold_cnt_q + TW'(1);
                end
                if (hold_cnt_q == TW'(TMO - 1)) begin
                    tmo_q <= 1'b1;
                end
            end else begin
                hold_cnt_q <= '0;
            end

            stall_cnt_q <= sat_inc(stall_cnt_q, hold_o[0]);
            flush_cnt_q <= sat_inc(flush_cnt_q, issue);
        end
    end

    assign tmo_o       = tmo_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
